// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32 core front end.
//   XLEN             architectural register / address width
//   INST_NOP         canonical NOP (addi x0, x0, 0), shown on o_inst when nothing is valid
//   RESET_PC_DEFAULT default fetch address after reset
//   PC_STEP          sequential fetch increment (one 32-bit instruction)
//   fetch_entry_t    one instruction-buffer entry: {pc, inst}
//   align_pc()       clears the two low address bits
package rv32_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Synchronous instruction buffer with flush.
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   flush_i  drop all entries; wins over push_i and pop_i
//   push_i   write wdata_i at the tail (caller guarantees not full)
//   wdata_i  entry to write
//   pop_i    drop the head entry (caller guarantees not empty)
//   count_o  number of valid entries, 0..Depth
//   head_o   entry at the head; only meaningful when count_o != 0
module rv32_fetch_fifo
  import rv32_pkg::*;
#(
  parameter int unsigned  Depth = 2,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  fetch_entry_t      wdata_i,
  input  logic              pop_i,
  output logic [CntW-1:0]   count_o,
  output fetch_entry_t      head_o
);

  fetch_entry_t          mem_q [Depth];
  fetch_entry_t          mem_d [Depth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        // Depth is a power of two, so natural pointer overflow is the modulo wrap.
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rv32_fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues requests to a 1-cycle-latency imem,
// buffers returned words with their PC and presents them to decode over valid/ready.
//   clk, rst                  clock (rising edge) and asynchronous active-high reset
//   o_imem_req, o_imem_addr   fetch request and word-aligned address
//   i_imem_rdata              instruction word, valid the cycle after a request
//   i_redirect, i_redirect_pc flush and restart fetch at the (aligned) target
//   o_valid, i_ready          decode handshake for the buffer head
//   o_inst, o_pc, o_pc_4      head instruction, its PC and PC + 4
module rv32_fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_4
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            squash_q, squash_d;

  logic [CntW-1:0] count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            issue;
  // One extra bit so the comparison against FIFO_DEPTH can never wrap.
  logic [CntW:0]   credits;

  assign o_valid = (count != '0);
  assign pop     = o_valid & i_ready;

  // Slots already spoken for once this cycle's pop and any in-flight response settle.
  assign credits = {1'b0, count} - (CntW + 1)'(pop) + (CntW + 1)'(inflight_q);
  assign issue   = !rst && !i_redirect && (credits < (CntW + 1)'(FIFO_DEPTH));

  assign push       = inflight_q & ~squash_q;
  assign push_entry = '{pc: inflight_pc_q, inst: i_imem_rdata};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    squash_d      = i_redirect;
    if (issue) begin
      fetch_pc_d    = fetch_pc_q + PC_STEP;
      inflight_pc_d = fetch_pc_q;
    end
    if (i_redirect) begin
      fetch_pc_d = align_pc(i_redirect_pc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      squash_q      <= squash_d;
    end
  end

  // Redirect flushes the buffer; the response landing this cycle belongs to the old path.
  rv32_fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (i_redirect),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .count_o (count),
    .head_o  (head)
  );

  assign o_imem_req  = issue;
  assign o_imem_addr = fetch_pc_q;

  // Deterministic idle values keep downstream decode from seeing stale words.
  assign o_inst = o_valid ? head.inst : INST_NOP;
  assign o_pc   = o_valid ? head.pc : RESET_PC;
  assign o_pc_4 = o_pc + PC_STEP;

endmodule
